// File: rtl/blake512_ctrl.sv
// BLAKE-512 compression controller: accepts message blocks, sequences INIT/ROUND/FINAL
// around an external round register, chains the chaining value h and hands out the digest.
module blake512_ctrl #(
  parameter int WWIDTH  = 64,
  parameter int NROUNDS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [16*WWIDTH-1:0] blk_data,
  input  logic [2*WWIDTH-1:0]  blk_cnt,
  input  logic                 blk_first,
  input  logic                 blk_last,
  input  logic                 blk_nullt,
  input  logic [4*WWIDTH-1:0]  salt,
  output logic                 init_round,
  output logic [3:0]           round_idx,
  output logic [16*WWIDTH-1:0] v_init_val,
  output logic [16*WWIDTH-1:0] block_reg,
  input  logic [16*WWIDTH-1:0] v_current,
  output logic                 dig_valid,
  input  logic                 dig_ready,
  output logic [8*WWIDTH-1:0]  dig_data,
  output logic                 busy
);
  localparam int W = WWIDTH;

  localparam logic [8*W-1:0] IV512 = {
    64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
    64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F, 64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179};

  localparam logic [8*W-1:0] CNST = {
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917};

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, OUT} state_t;

  state_t          state, state_nxt;
  logic [8*W-1:0]  h, h_fin;
  logic [3:0]      r;
  logic [16*W-1:0] blk;
  logic [2*W-1:0]  cnt;
  logic            last, nullt;
  logic [W-1:0]    t0, t1;
  logic            last_round;

  assign last_round = (r == 4'(NROUNDS - 1));

  // A padding-only block contributes no counter to the initial state.
  assign t0 = nullt ? '0 : cnt[W-1:0];
  assign t1 = nullt ? '0 : cnt[2*W-1:W];

  assign v_init_val = {h, salt ^ CNST[8*W-1:4*W], {t0, t0, t1, t1} ^ CNST[4*W-1:0]};
  assign block_reg  = blk;
  assign round_idx  = r;
  assign dig_data   = dig_valid ? h : '0;

  always_comb begin
    h_fin = '0;
    for (int i = 0; i < 8; i++) begin
      h_fin[(7-i)*W +: W] = h[(7-i)*W +: W] ^ salt[(3-(i%4))*W +: W]
                          ^ v_current[(15-i)*W +: W] ^ v_current[(7-i)*W +: W];
    end
  end

  always_comb begin
    state_nxt  = state;
    blk_ready  = 1'b0;
    init_round = 1'b0;
    dig_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        blk_ready = 1'b1;
        if (blk_valid) state_nxt = INIT;
      end
      INIT: begin
        init_round = 1'b1;
        state_nxt  = ROUND;
      end
      ROUND: begin
        if (last_round) state_nxt = FINAL;
      end
      FINAL: begin
        state_nxt = last ? OUT : IDLE;
      end
      OUT: begin
        dig_valid = 1'b1;
        if (dig_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are forced quiet while reset is held, even before the state is known.
    if (rst) begin
      blk_ready  = 1'b0;
      init_round = 1'b0;
      dig_valid  = 1'b0;
      busy       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      h     <= '0;
      r     <= '0;
      blk   <= '0;
      cnt   <= '0;
      last  <= 1'b0;
      nullt <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (blk_valid) begin
            blk   <= blk_data;
            cnt   <= blk_cnt;
            last  <= blk_last;
            nullt <= blk_nullt;
            if (blk_first) h <= IV512;
          end
        end
        ROUND:   r <= last_round ? '0 : r + 4'd1;
        FINAL:   h <= h_fin;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_blake512_ctrl.sv
// Bench for blake512_ctrl: emulates the external round register with a behavioural BLAKE-512
// round and checks digests, timing, backpressure, counter masking and mid-run reset.
module tb_blake512_ctrl;
  typedef logic [63:0] w64;

  localparam int NR = 16;
  localparam int NV = 10;

  localparam w64 CC [16] = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69};

  localparam int SIG [10][16] = '{
    '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
    '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
    '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
    '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
    '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
    '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
    '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
    '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
    '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}};

  localparam int GA [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  localparam int GB [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
  localparam int GC [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
  localparam int GD [8] = '{12, 13, 14, 15, 15, 12, 13, 14};

  localparam logic [511:0] IV = {
    64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
    64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F, 64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179};

  localparam logic [511:0] EMPTY_DIG = 512'ha8cfbbd73726062df0c6864dda65defe58ef0cc52a5625090fa17601e1eecd1b628e94f396ae402a00acc9eab77b4d4c2e852aaaa25a636d80af3fc7913ef5b8;

  typedef struct {
    logic [1023:0] data;
    logic [127:0]  cnt;
    logic [255:0]  salt;
    bit            first;
    bit            last;
    bit            nullt;
    logic [511:0]  exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          blk_valid, blk_ready;
  logic [1023:0] blk_data;
  logic [127:0]  blk_cnt;
  logic          blk_first, blk_last, blk_nullt;
  logic [255:0]  salt;
  logic          init_round;
  logic [3:0]    round_idx;
  logic [1023:0] v_init_val, block_reg, v_current;
  logic          dig_valid, dig_ready;
  logic [511:0]  dig_data;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  logic dv_prev = 1'b0;
  logic [1023:0] vreg = '0;
  int rsteps = 0;

  blake512_ctrl #(.WWIDTH(64), .NROUNDS(NR)) dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_cnt(blk_cnt), .blk_first(blk_first), .blk_last(blk_last), .blk_nullt(blk_nullt),
    .salt(salt), .init_round(init_round), .round_idx(round_idx), .v_init_val(v_init_val),
    .block_reg(block_reg), .v_current(v_current), .dig_valid(dig_valid), .dig_ready(dig_ready),
    .dig_data(dig_data), .busy(busy));

  always #5 clk = ~clk;

  function automatic w64 ror(input w64 x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [255:0] gfn(input w64 a, b, c, d, mx, my, cx, cy);
    a = a + b + (mx ^ cy); d = ror(d ^ a, 32); c = c + d; b = ror(b ^ c, 25);
    a = a + b + (my ^ cx); d = ror(d ^ a, 16); c = c + d; b = ror(b ^ c, 11);
    return {a, b, c, d};
  endfunction

  function automatic logic [1023:0] round_fn(input logic [1023:0] vin, input logic [1023:0] mb, input int r);
    w64 v [16];
    w64 m [16];
    logic [1023:0] o;
    int s, x, y;
    s = r % 10;
    for (int i = 0; i < 16; i++) begin
      v[i] = vin[1023-64*i -: 64];
      m[i] = mb[1023-64*i -: 64];
    end
    for (int j = 0; j < 8; j++) begin
      x = SIG[s][2*j];
      y = SIG[s][2*j+1];
      {v[GA[j]], v[GB[j]], v[GC[j]], v[GD[j]]} =
        gfn(v[GA[j]], v[GB[j]], v[GC[j]], v[GD[j]], m[x], m[y], CC[x], CC[y]);
    end
    for (int i = 0; i < 16; i++) o[1023-64*i -: 64] = v[i];
    return o;
  endfunction

  function automatic logic [511:0] compress(input logic [511:0] h, input logic [1023:0] m,
                                            input logic [255:0] s, input logic [127:0] t, input bit nt);
    logic [1023:0] v;
    logic [511:0] o;
    w64 t0, t1;
    t0 = nt ? 64'd0 : t[63:0];
    t1 = nt ? 64'd0 : t[127:64];
    v[1023:512] = h;
    for (int i = 0; i < 4; i++) v[511-64*i -: 64] = s[255-64*i -: 64] ^ CC[i];
    v[255:0] = {t0 ^ CC[4], t0 ^ CC[5], t1 ^ CC[6], t1 ^ CC[7]};
    for (int r = 0; r < NR; r++) v = round_fn(v, m, r);
    for (int i = 0; i < 8; i++)
      o[511-64*i -: 64] = h[511-64*i -: 64] ^ s[255-64*(i%4) -: 64] ^ v[1023-64*i -: 64] ^ v[511-64*i -: 64];
    return o;
  endfunction

  function automatic logic [1023:0] rnd_bits();
    logic [1023:0] x;
    for (int i = 0; i < 32; i++) x[32*i +: 32] = $urandom;
    return x;
  endfunction

  // Round register emulation: loads on init_round, then one round per cycle indexed by round_idx.
  always @(posedge clk) begin
    if (rst) rsteps <= 0;
    else if (init_round) begin
      vreg   <= v_init_val;
      rsteps <= NR;
    end else if (rsteps > 0) begin
      vreg   <= round_fn(vreg, block_reg, int'(round_idx));
      rsteps <= rsteps - 1;
    end
  end
  assign v_current = vreg;

  always @(negedge clk) begin
    if (dig_valid && !dv_prev) pulses <= pulses + 1;
    dv_prev <= dig_valid;
  end

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_block(input logic [1023:0] d, input logic [127:0] c, input logic [255:0] s,
                            input bit f, input bit l, input bit n);
    bit ok = 0;
    @(negedge clk);
    blk_data = d; blk_cnt = c; salt = s; blk_first = f; blk_last = l; blk_nullt = n;
    blk_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (blk_ready) ok = 1;
      else @(negedge clk);
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: blk_ready got 0 required 1 within 60 cycles");
    end
    @(posedge clk);
    #1 blk_valid = 1'b0;
  endtask

  task automatic wait_digest(output logic [511:0] d);
    bit got = 0;
    d = '0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (dig_valid) begin
        got = 1;
        d = dig_data;
      end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL digest_timeout: dig_valid got 0 required 1 within 40 cycles");
    end else begin
      dig_ready = 1'b1;
      @(posedge clk);
      #1 dig_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [NV];
    logic [1023:0] empty, d1, d2;
    logic [511:0] mh, dg, d0, h1;
    logic [255:0] cur_salt, s;
    logic [127:0] c;
    int nlast, pb;
    bit found;

    rst = 1'b1; blk_valid = 1'b0; blk_data = '0; blk_cnt = '0; blk_first = 1'b0;
    blk_last = 1'b0; blk_nullt = 1'b0; salt = '0; dig_ready = 1'b0;

    empty = '0;
    empty[1023:960] = 64'h8000000000000000;
    empty[191:128]  = 64'h0000000000000001;

    tbl[0].data = empty; tbl[0].cnt = '0; tbl[0].salt = '0;
    tbl[0].first = 1; tbl[0].last = 1; tbl[0].nullt = 0; tbl[0].exp = EMPTY_DIG;
    mh = EMPTY_DIG;
    cur_salt = '0;
    nlast = 1;
    for (int k = 1; k < NV; k++) begin
      tbl[k].first = (k == 1) || ($urandom_range(0, 2) == 0);
      tbl[k].last  = (k == NV - 1) || ($urandom_range(0, 1) == 0);
      tbl[k].nullt = ($urandom_range(0, 3) == 0);
      if (tbl[k].first) cur_salt = rnd_bits()[255:0];
      tbl[k].salt = cur_salt;
      tbl[k].data = rnd_bits();
      tbl[k].cnt  = rnd_bits()[127:0];
      mh = compress(tbl[k].first ? IV : mh, tbl[k].data, tbl[k].salt, tbl[k].cnt, tbl[k].nullt);
      tbl[k].exp = tbl[k].last ? mh : '0;
      if (tbl[k].last) nlast++;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_init_round", init_round, 0);
    chk("rst_dig_valid", dig_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dig_data", dig_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_blk_ready", blk_ready, 1);
    chk("post_rst_block_reg", block_reg, 0);
    chk("post_rst_round_idx", round_idx, 0);
    chk("post_rst_v_init_h", v_init_val[1023:512], 0);

    // Timing of one empty-message block
    send_block(empty, '0, '0, 1, 1, 0);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      chk($sformatf("init_round_c%0d", k), init_round, k == 1);
      if (k >= 2 && k <= 17) chk($sformatf("round_idx_c%0d", k), round_idx, k - 2);
      chk($sformatf("dig_valid_c%0d", k), dig_valid, k == 19);
      chk($sformatf("busy_c%0d", k), busy, 1);
    end
    chk("timing_block_reg", block_reg, empty);

    // Backpressure in OUT
    d0 = dig_data;
    chk("empty_digest", d0, EMPTY_DIG);
    blk_data = rnd_bits(); blk_first = 1'b1; blk_last = 1'b1; blk_valid = 1'b1;
    for (int c2 = 0; c2 < 5; c2++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_dig_valid_%0d", c2), dig_valid, 1);
      chk($sformatf("bp_dig_data_%0d", c2), dig_data, d0);
      chk($sformatf("bp_blk_ready_%0d", c2), blk_ready, 0);
      chk($sformatf("bp_block_reg_%0d", c2), block_reg, empty);
    end
    blk_valid = 1'b0;
    dig_ready = 1'b1;
    @(posedge clk);
    #1 dig_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_busy", busy, 0);
    chk("bp_release_blk_ready", blk_ready, 1);
    chk("bp_release_dig_valid", dig_valid, 0);

    // Table of randomized chained messages
    @(negedge clk);
    pb = pulses;
    for (int k = 0; k < NV; k++) begin
      send_block(tbl[k].data, tbl[k].cnt, tbl[k].salt, tbl[k].first, tbl[k].last, tbl[k].nullt);
      if (tbl[k].last) begin
        wait_digest(dg);
        chk($sformatf("tbl_digest_%0d", k), dg, tbl[k].exp);
      end
    end
    send_block(empty, '0, '0, 1, 0, 0);
    repeat (22) @(negedge clk);
    chk("tbl_pulse_count", pulses - pb, nlast);

    // Counter masking with nullt
    d1 = rnd_bits(); s = rnd_bits()[255:0];
    send_block(d1, {128{1'b1}}, s, 1, 1, 1);
    @(negedge clk);
    chk("nullt_init_round", init_round, 1);
    chk("nullt_v12_15", v_init_val[255:0], {CC[4], CC[5], CC[6], CC[7]});
    chk("nullt_v0_7", v_init_val[1023:512], IV);
    chk("nullt_v8_11", v_init_val[511:256], s ^ {CC[0], CC[1], CC[2], CC[3]});
    wait_digest(dg);
    chk("nullt_digest", dg, compress(IV, d1, s, {128{1'b1}}, 1));
    c = rnd_bits()[127:0];
    send_block(d1, c, s, 1, 1, 0);
    @(negedge clk);
    chk("cnt_v12_15", v_init_val[255:0],
        {c[63:0] ^ CC[4], c[63:0] ^ CC[5], c[127:64] ^ CC[6], c[127:64] ^ CC[7]});
    wait_digest(dg);
    chk("cnt_digest", dg, compress(IV, d1, s, c, 0));

    // Two-block message
    d1 = rnd_bits(); d2 = rnd_bits(); s = rnd_bits()[255:0]; c = rnd_bits()[127:0];
    h1 = compress(IV, d1, s, c, 0);
    @(negedge clk);
    pb = pulses;
    send_block(d1, c, s, 1, 0, 0);
    send_block(d2, c + 128'd1024, s, 0, 1, 0);
    wait_digest(dg);
    chk("two_block_digest", dg, compress(h1, d2, s, c + 128'd1024, 0));
    @(negedge clk);
    chk("two_block_pulses", pulses - pb, 1);

    // Reset during ROUND at r = 7
    send_block(empty, '0, '0, 1, 1, 0);
    found = 0;
    for (int c3 = 0; c3 < 30 && !found; c3++) begin
      @(negedge clk);
      if (busy && !init_round && round_idx == 4'd7) found = 1;
    end
    chk("mid_rst_reach_r7", found, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    pb = pulses;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dig_valid", dig_valid, 0);
    chk("mid_rst_dig_data", dig_data, 0);
    chk("mid_rst_init_round", init_round, 0);
    chk("mid_rst_blk_ready", blk_ready, 1);
    chk("mid_rst_round_idx", round_idx, 0);
    chk("mid_rst_block_reg", block_reg, 0);
    send_block(empty, '0, '0, 1, 1, 0);
    wait_digest(dg);
    chk("mid_rst_empty_digest", dg, EMPTY_DIG);
    @(negedge clk);
    chk("mid_rst_pulses", pulses - pb, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
